alct_rx_sync_checker: RTL and testbench

Checks ALCT receive-link integrity downstream of the 80 MHz→40 MHz ALCT DDR demultiplexer. The block consumes each demultiplexed 1st-in-time/2nd-in-time word pair in the 40 MHz main clock domain and compares it against an expected sync pattern, either a fixed pattern or a self-seeding counter. It reports lock status and an error pulse, and keeps a saturating error count plus a capture of the first bad word pair. VME status logic reads its outputs while the ALCT rx clock-delay and posneg settings are being scanned.

---
 rtl/alct_rx_sync_checker_pkg.sv | 26 ++
 rtl/alct_sync_expect.sv | 40 ++++
 rtl/alct_rx_sync_checker.sv | 184 ++++++++++++++++++
 tb/tb_alct_rx_sync_checker.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/alct_rx_sync_checker_pkg.sv
// ============================================================================
// Module : alct_rx_sync_checker_pkg
// Brief  : State codes, default thresholds and helpers for the ALCT rx sync checker
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package alct_rx_sync_checker_pkg;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SEARCH = 2'd1,
        S_LOCKED = 2'd2
    } state_t;

    localparam int LOCK_CNT_DEF = 16;
    localparam int LOSE_CNT_DEF = 4;
    localparam int ERR_CNT_W    = 16;

    function automatic logic [ERR_CNT_W-1:0] sat_inc(input logic [ERR_CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/alct_sync_expect.sv
// ============================================================================
// Module : alct_sync_expect
// Brief  : Expected-word generator: fixed pattern or self-seeding counter
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module alct_sync_expect #(
    parameter int WIDTH = 28
) (
    input  logic             i_mode,
    input  logic [WIDTH-1:0] i_pat1st,
    input  logic [WIDTH-1:0] i_pat2nd,
    input  logic [WIDTH-1:0] i_d1,
    input  logic             i_exp_clr,
    input  logic             i_exp_reseed,
    input  logic             i_exp_adv,
    input  logic [WIDTH-1:0] i_exp_q,
    output logic [WIDTH-1:0] o_exp1st,
    output logic [WIDTH-1:0] o_exp2nd,
    output logic [WIDTH-1:0] o_exp_d
);

    // In counter mode the 2nd word is always the complement of the 1st.
    always_comb begin
        o_exp1st = i_mode ? i_exp_q : i_pat1st;
        o_exp2nd = i_mode ? ~i_d1   : i_pat2nd;
        o_exp_d  = i_exp_q;
        if (i_exp_clr) begin
            o_exp_d = '0;
        end else if (i_exp_reseed) begin
            o_exp_d = i_d1 + 1'b1;
        end else if (i_exp_adv) begin
            o_exp_d = i_exp_q + 1'b1;
        end
    end

endmodule

`default_nettype wire

// File: rtl/alct_rx_sync_checker.sv
// ============================================================================
// Module : alct_rx_sync_checker
// Brief  : ALCT demux word-pair sync checker with lock FSM, error count, capture
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module alct_rx_sync_checker
    import alct_rx_sync_checker_pkg::*;
#(
    parameter int WIDTH    = 28,
    parameter int LOCK_CNT = LOCK_CNT_DEF,
    parameter int LOSE_CNT = LOSE_CNT_DEF
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             check_en,
    input  logic             mode,
    input  logic             clr_err,
    input  logic [WIDTH-1:0] pat1st,
    input  logic [WIDTH-1:0] pat2nd,
    input  logic [WIDTH-1:0] din1st,
    input  logic [WIDTH-1:0] din2nd,
    output logic             locked,
    output logic             err_pulse,
    output logic [15:0]      err_cnt,
    output logic [WIDTH-1:0] bad1st,
    output logic [WIDTH-1:0] bad2nd,
    output logic [1:0]       state
);

    localparam int RUN_W  = (LOCK_CNT > 1) ? $clog2(LOCK_CNT) : 1;
    localparam int MISS_W = (LOSE_CNT > 1) ? $clog2(LOSE_CNT) : 1;

    state_t            state_q, state_d;
    logic [WIDTH-1:0]  d1_q, d1_d, d2_q, d2_d;
    logic [WIDTH-1:0]  exp_q, exp_d;
    logic [WIDTH-1:0]  bad1_q, bad1_d, bad2_q, bad2_d;
    logic [RUN_W-1:0]  run_q, run_d;
    logic [MISS_W-1:0] miss_q, miss_d;
    logic [15:0]       cnt_q, cnt_d;
    logic              seen_q, seen_d;
    logic              pulse_q, pulse_d;

    logic [WIDTH-1:0]  w_exp1st, w_exp2nd;
    logic              w_match, w_err, w_run_last, w_miss_last;
    logic              w_exp_clr, w_exp_reseed, w_exp_adv;

    alct_sync_expect #(.WIDTH(WIDTH)) u_expect (
        .i_mode       (mode),
        .i_pat1st     (pat1st),
        .i_pat2nd     (pat2nd),
        .i_d1         (d1_q),
        .i_exp_clr    (w_exp_clr),
        .i_exp_reseed (w_exp_reseed),
        .i_exp_adv    (w_exp_adv),
        .i_exp_q      (exp_q),
        .o_exp1st     (w_exp1st),
        .o_exp2nd     (w_exp2nd),
        .o_exp_d      (exp_d)
    );

    assign w_match     = (d1_q == w_exp1st) && (d2_q == w_exp2nd);
    assign w_run_last  = (32'(run_q)  + 32'd1) == 32'(LOCK_CNT);
    assign w_miss_last = (32'(miss_q) + 32'd1) == 32'(LOSE_CNT);

    always_comb begin
        state_d      = state_q;
        run_d        = run_q;
        miss_d       = miss_q;
        w_exp_clr    = 1'b0;
        w_exp_reseed = 1'b0;
        w_exp_adv    = 1'b0;
        w_err        = 1'b0;
        if (!check_en) begin
            state_d   = S_IDLE;
            run_d     = '0;
            miss_d    = '0;
            w_exp_clr = 1'b1;
        end else begin
            case (state_q)
                S_IDLE: begin
                    state_d   = S_SEARCH;
                    run_d     = '0;
                    miss_d    = '0;
                    w_exp_clr = 1'b1;
                end
                S_SEARCH: begin
                    if (w_match) begin
                        w_exp_adv = mode;
                        if (w_run_last) begin
                            state_d = S_LOCKED;
                            run_d   = '0;
                        end else begin
                            run_d = run_q + 1'b1;
                        end
                    end else begin
                        run_d        = '0;
                        w_exp_reseed = mode;
                    end
                end
                S_LOCKED: begin
                    // Counter keeps free-running while locked so one bad word cannot shift it.
                    w_exp_adv = mode;
                    if (w_match) begin
                        miss_d = '0;
                    end else begin
                        w_err = 1'b1;
                        if (w_miss_last) begin
                            state_d = S_SEARCH;
                            run_d   = '0;
                            miss_d  = '0;
                        end else begin
                            miss_d = miss_q + 1'b1;
                        end
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_comb begin
        d1_d    = din1st;
        d2_d    = din2nd;
        pulse_d = w_err;
        cnt_d   = cnt_q;
        bad1_d  = bad1_q;
        bad2_d  = bad2_q;
        seen_d  = seen_q;
        // Clear wins over a same-cycle error; that error is neither counted nor captured.
        if (clr_err) begin
            cnt_d  = '0;
            bad1_d = '0;
            bad2_d = '0;
            seen_d = 1'b0;
        end else if (w_err) begin
            cnt_d = sat_inc(cnt_q);
            if (!seen_q) begin
                bad1_d = d1_q;
                bad2_d = d2_q;
                seen_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            d1_q    <= '0;
            d2_q    <= '0;
            exp_q   <= '0;
            run_q   <= '0;
            miss_q  <= '0;
            cnt_q   <= '0;
            bad1_q  <= '0;
            bad2_q  <= '0;
            seen_q  <= 1'b0;
            pulse_q <= 1'b0;
        end else begin
            state_q <= state_d;
            d1_q    <= d1_d;
            d2_q    <= d2_d;
            exp_q   <= exp_d;
            run_q   <= run_d;
            miss_q  <= miss_d;
            cnt_q   <= cnt_d;
            bad1_q  <= bad1_d;
            bad2_q  <= bad2_d;
            seen_q  <= seen_d;
            pulse_q <= pulse_d;
        end
    end

    assign locked    = (state_q == S_LOCKED);
    assign err_pulse = pulse_q;
    assign err_cnt   = cnt_q;
    assign bad1st    = bad1_q;
    assign bad2nd    = bad2_q;
    assign state     = state_q;

endmodule

`default_nettype wire

// File: tb/tb_alct_rx_sync_checker.sv
// ============================================================================
// Module : tb_alct_rx_sync_checker
// Brief  : Scoreboard bench with behavioural reference model for the sync checker
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_alct_rx_sync_checker;

    localparam int W    = 28;
    localparam int LOCK = 16;
    localparam int LOSE = 4;
    localparam logic [W-1:0] P1 = 28'h5A5A5A5;
    localparam logic [W-1:0] P2 = 28'hA5A5A5A;

    typedef logic [75:0] ovec_t;

    logic          clock = 1'b0;
    logic          reset_n;
    logic          check_en, mode, clr_err;
    logic [W-1:0]  pat1st, pat2nd, din1st, din2nd;
    logic          locked, err_pulse;
    logic [15:0]   err_cnt;
    logic [W-1:0]  bad1st, bad2nd;
    logic [1:0]    state;

    logic          rst_s_n, s_en;
    logic [W-1:0]  s_d1, s_d2;
    logic          locked_s, err_pulse_s;
    logic [15:0]   err_cnt_s;
    logic [W-1:0]  bad1st_s, bad2nd_s;
    logic [1:0]    state_s;

    int n_chk  = 0;
    int n_pass = 0;

    always #5 clock = ~clock;

    alct_rx_sync_checker #(.WIDTH(W), .LOCK_CNT(LOCK), .LOSE_CNT(LOSE)) u_dut (
        .clock(clock), .reset_n(reset_n), .check_en(check_en), .mode(mode),
        .clr_err(clr_err), .pat1st(pat1st), .pat2nd(pat2nd),
        .din1st(din1st), .din2nd(din2nd), .locked(locked), .err_pulse(err_pulse),
        .err_cnt(err_cnt), .bad1st(bad1st), .bad2nd(bad2nd), .state(state)
    );

    // Instance that never drops lock, used to drive err_cnt into saturation.
    alct_rx_sync_checker #(.WIDTH(W), .LOCK_CNT(LOCK), .LOSE_CNT(1 << 20)) u_sat (
        .clock(clock), .reset_n(rst_s_n), .check_en(s_en), .mode(1'b0),
        .clr_err(1'b0), .pat1st(P1), .pat2nd(P2),
        .din1st(s_d1), .din2nd(s_d2), .locked(locked_s), .err_pulse(err_pulse_s),
        .err_cnt(err_cnt_s), .bad1st(bad1st_s), .bad2nd(bad2nd_s), .state(state_s)
    );

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s at %0t: got %h, want %h", name, $time, act, exp);
    endtask

    // ---------------- reference model ----------------
    int           m_st, m_run, m_miss;
    logic [W-1:0] m_exp, m_d1, m_d2, m_bad1, m_bad2;
    logic [15:0]  m_cnt;
    bit           m_seen, m_pulse;
    ovec_t        sb[$];

    task automatic m_reset();
        m_st = 0; m_run = 0; m_miss = 0;
        m_exp = '0; m_d1 = '0; m_d2 = '0; m_bad1 = '0; m_bad2 = '0;
        m_cnt = '0; m_seen = 0; m_pulse = 0;
    endtask

    function automatic ovec_t m_out();
        return {m_st == 2, m_pulse, m_cnt, m_bad1, m_bad2, 2'(m_st)};
    endfunction

    task automatic m_step();
        bit match, err;
        err   = 0;
        match = mode ? (m_d1 == m_exp && m_d2 == ~m_d1) : (m_d1 == pat1st && m_d2 == pat2nd);
        if (!check_en || m_st == 0) begin
            m_st = check_en ? 1 : 0;
            m_run = 0; m_miss = 0; m_exp = '0;
        end else if (m_st == 1) begin
            if (match) begin
                m_run++;
                if (mode) m_exp = m_exp + 1'b1;
                if (m_run == LOCK) begin m_st = 2; m_run = 0; end
            end else begin
                m_run = 0;
                if (mode) m_exp = m_d1 + 1'b1;
            end
        end else begin
            if (mode) m_exp = m_exp + 1'b1;
            if (match) m_miss = 0;
            else begin
                err = 1;
                m_miss++;
                if (m_miss == LOSE) begin m_st = 1; m_run = 0; m_miss = 0; end
            end
        end
        m_pulse = err;
        if (clr_err) begin
            m_cnt = '0; m_bad1 = '0; m_bad2 = '0; m_seen = 0;
        end else if (err) begin
            if (m_cnt != 16'hFFFF) m_cnt = m_cnt + 1'b1;
            if (!m_seen) begin m_bad1 = m_d1; m_bad2 = m_d2; m_seen = 1; end
        end
        m_d1 = din1st;
        m_d2 = din2nd;
    endtask

    always @(posedge clock) begin
        if (reset_n) m_step();
        else m_reset();
        sb.push_back(m_out());
    end

    // An asynchronous reset replaces the pending expectation with the reset state.
    always @(negedge reset_n) begin
        m_reset();
        if (sb.size() > 0) begin
            sb.delete();
            sb.push_back(m_out());
        end
    end

    // ---------------- monitor ----------------
    always @(negedge clock) begin : monitor
        ovec_t e;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            chk("outputs{lock,pulse,cnt,bad1,bad2,state}",
                {locked, err_pulse, err_cnt, bad1st, bad2nd, state}, e);
        end
    end

    // ---------------- stimulus ----------------
    function automatic logic [W-1:0] flip(input logic [W-1:0] v);
        logic [W-1:0] one;
        one = 1;
        return v ^ (one << ($urandom % W));
    endfunction

    task automatic cyc(input bit en, input bit md, input bit clr,
                       input logic [W-1:0] a, input logic [W-1:0] b);
        @(negedge clock);
        check_en = en; mode = md; clr_err = clr; din1st = a; din2nd = b;
    endtask

    task automatic s_drive(input logic [W-1:0] a, input logic [W-1:0] b);
        @(negedge clock);
        s_d1 = a; s_d2 = b;
    endtask

    task automatic main_seq();
        logic [W-1:0] v, a, b;
        int r;
        // fixed pattern lock
        repeat (24) cyc(1, 0, 0, P1, P2);
        // single corrupt pair
        cyc(1, 0, 0, P1 ^ 28'h8, P2);
        repeat (6) cyc(1, 0, 0, P1, P2);
        // four mismatches drop lock, then relock
        repeat (4) cyc(1, 0, 0, P1 ^ 28'h1, P2 ^ 28'h10);
        repeat (24) cyc(1, 0, 0, P1, P2);
        // clear coincident with a locked error, then a fresh error
        cyc(1, 0, 0, P1 ^ 28'h8, P2);
        cyc(1, 0, 1, P1, P2);
        repeat (4) cyc(1, 0, 0, P1, P2);
        cyc(1, 0, 0, P1, P2 ^ 28'h100);
        repeat (4) cyc(1, 0, 0, P1, P2);
        // random fixed-mode traffic
        for (int i = 0; i < 400; i++) begin
            r = $urandom % 100;
            a = (r < 8) ? flip(P1) : P1;
            b = (r >= 8 && r < 12) ? flip(P2) : P2;
            cyc(($urandom % 60) != 0, 0, ($urandom % 30) == 0, a, b);
        end
        // counter mode through the wrap
        repeat (3) cyc(0, 1, 0, '0, '0);
        v = 28'hFFFFFC0;
        for (int i = 0; i < 90; i++) begin
            cyc(1, 1, 0, v, ~v);
            v = v + 1'b1;
        end
        // random counter traffic
        for (int i = 0; i < 300; i++) begin
            r = $urandom % 100;
            a = v; b = ~v;
            if (r < 8) a = flip(a);
            else if (r < 12) b = flip(b);
            else if (r < 14) v = v + W'($urandom);
            cyc(($urandom % 100) != 0, 1, ($urandom % 30) == 0, a, b);
            v = v + 1'b1;
        end
        for (int i = 0; i < 30; i++) begin
            cyc(1, 1, 0, v, ~v);
            v = v + 1'b1;
        end
        // asynchronous reset mid-operation
        @(posedge clock);
        #2 reset_n = 1'b0;
        #1 chk("async_reset_outputs",
               {locked, err_pulse, err_cnt, bad1st, bad2nd, state}, '0);
        repeat (2) @(negedge clock);
        reset_n = 1'b1;
        for (int i = 0; i < 25; i++) begin
            cyc(1, 1, 0, v, ~v);
            v = v + 1'b1;
        end
    endtask

    task automatic sat_seq();
        s_en = 1'b1;
        repeat (20) s_drive(P1, P2);
        repeat (65534) s_drive(P1 ^ 28'h1, P2);
        repeat (3) s_drive(P1, P2);
        #1;
        chk("sat_cnt_fffe", err_cnt_s, 16'hFFFE);
        chk("sat_locked", locked_s, 1'b1);
        chk("sat_bad1st", bad1st_s, P1 ^ 28'h1);
        chk("sat_bad2nd", bad2nd_s, P2);
        repeat (5) s_drive(P1 ^ 28'h1, P2);
        repeat (3) s_drive(P1, P2);
        #1 chk("sat_cnt_ffff", err_cnt_s, 16'hFFFF);
        repeat (3) s_drive(P1 ^ 28'h2, P2);
        repeat (3) s_drive(P1, P2);
        #1 chk("sat_cnt_hold", err_cnt_s, 16'hFFFF);
    endtask

    initial begin
        reset_n = 1'b0; rst_s_n = 1'b0;
        check_en = 1'b0; mode = 1'b0; clr_err = 1'b0;
        pat1st = P1; pat2nd = P2; din1st = '0; din2nd = '0;
        s_en = 1'b0; s_d1 = '0; s_d2 = '0;
        repeat (3) @(negedge clock);
        reset_n = 1'b1; rst_s_n = 1'b1;
        fork
            main_seq();
            sat_seq();
        join
        repeat (3) @(negedge clock);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #1_500_000;
        $display("FAIL watchdog: got no completion by %0t, want completion", $time);
        $fatal(1, "timeout");
    end

endmodule

`default_nettype wire
